// File: rtl/pe_dataflow_sequencer.sv
// Per-PE sequencer: walks layer/k/c loops, drives LOAD -> COMPUTE -> PPU phases and
// issues I x F activation/weight groups to the multiplier array from latched tile counts.
module pe_dataflow_sequencer #(
   parameter int unsigned I     = 4,
   parameter int unsigned F     = 4,
   parameter int unsigned MAX_A = 64,
   parameter int unsigned MAX_W = 64,
   parameter int unsigned K_W   = 4,
   parameter int unsigned C_W   = 4,
   parameter int unsigned L_W   = 3,
   localparam int unsigned AW   = $clog2(MAX_A) + 1,
   localparam int unsigned WW   = $clog2(MAX_W) + 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic           abort,
   input  logic [L_W-1:0] cfg_num_layers,
   input  logic [K_W-1:0] cfg_num_k,
   input  logic [C_W-1:0] cfg_num_c,
   input  logic           load_done,
   input  logic [AW-1:0]  load_cnt_a,
   input  logic [WW-1:0]  load_cnt_w,
   input  logic           mul_ready,
   input  logic           ppu_done,
   output logic [2:0]     state,
   output logic [L_W-1:0] current_layer,
   output logic [K_W-1:0] current_k,
   output logic [C_W-1:0] current_c,
   output logic [AW-1:0]  current_a,
   output logic [WW-1:0]  current_w,
   output logic [AW-1:0]  remain_a,
   output logic [WW-1:0]  remain_w,
   output logic           flag_remain_a,
   output logic           flag_remain_w,
   output logic           mul_valid,
   output logic           busy,
   output logic           done
);

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StLoad    = 3'd1,
      StCompute = 3'd2,
      StPpu     = 3'd3,
      StDone    = 3'd4
   } state_e;

   state_e         state_q, state_d;
   logic [L_W-1:0] cfg_layers_q, cfg_layers_d;
   logic [K_W-1:0] cfg_k_q, cfg_k_d;
   logic [C_W-1:0] cfg_c_q, cfg_c_d;
   logic [L_W-1:0] layer_q, layer_d;
   logic [K_W-1:0] k_q, k_d;
   logic [C_W-1:0] c_q, c_d;
   logic [AW-1:0]  a_q, a_d;
   logic [WW-1:0]  w_q, w_d;
   logic [AW-1:0]  cnt_a_q, cnt_a_d;
   logic [WW-1:0]  cnt_w_q, cnt_w_d;
   logic           done_q, done_d;

   // One extra bit so the look-ahead sum never wraps before the compare.
   logic [AW:0] a_sum;
   logic [WW:0] w_sum;
   logic        last_a, last_w, phase_end;

   assign a_sum  = {1'b0, a_q} + (AW+1)'(I);
   assign w_sum  = {1'b0, w_q} + (WW+1)'(F);
   assign last_a = a_sum >= {1'b0, cnt_a_q};
   assign last_w = w_sum >= {1'b0, cnt_w_q};

   assign state         = state_q;
   assign current_layer = layer_q;
   assign current_k     = k_q;
   assign current_c     = c_q;
   assign current_a     = a_q;
   assign current_w     = w_q;
   assign remain_a      = cnt_a_q - a_q;
   assign remain_w      = cnt_w_q - w_q;
   assign flag_remain_a = remain_a >= AW'(I);
   assign flag_remain_w = remain_w >= WW'(F);
   assign mul_valid     = (state_q == StCompute) && (cnt_a_q != '0) && (cnt_w_q != '0);
   assign busy          = (state_q != StIdle) && (state_q != StDone);
   assign done          = done_q;

   always_comb begin
      state_d      = state_q;
      cfg_layers_d = cfg_layers_q;
      cfg_k_d      = cfg_k_q;
      cfg_c_d      = cfg_c_q;
      layer_d      = layer_q;
      k_d          = k_q;
      c_d          = c_q;
      a_d          = a_q;
      w_d          = w_q;
      cnt_a_d      = cnt_a_q;
      cnt_w_d      = cnt_w_q;
      done_d       = 1'b0;
      phase_end    = 1'b0;

      if (abort) begin
         state_d = StIdle;
         layer_d = '0;
         k_d     = '0;
         c_d     = '0;
         a_d     = '0;
         w_d     = '0;
         cnt_a_d = '0;
         cnt_w_d = '0;
      end else begin
         case (state_q)
            StIdle, StDone: begin
               if (start) begin
                  cfg_layers_d = cfg_num_layers;
                  cfg_k_d      = cfg_num_k;
                  cfg_c_d      = cfg_num_c;
                  layer_d      = '0;
                  k_d          = '0;
                  c_d          = '0;
                  a_d          = '0;
                  w_d          = '0;
                  cnt_a_d      = '0;
                  cnt_w_d      = '0;
                  state_d      = StLoad;
               end
            end
            StLoad: begin
               if (load_done) begin
                  cnt_a_d = load_cnt_a;
                  cnt_w_d = load_cnt_w;
                  a_d     = '0;
                  w_d     = '0;
                  state_d = StCompute;
               end
            end
            StCompute: begin
               // An empty tile still spends one cycle here with nothing issued.
               if (!mul_valid) begin
                  phase_end = 1'b1;
               end else if (mul_ready) begin
                  if (last_a) begin
                     a_d = '0;
                     if (last_w) phase_end = 1'b1;
                     else        w_d = w_sum[WW-1:0];
                  end else begin
                     a_d = a_sum[AW-1:0];
                  end
               end
               if (phase_end) begin
                  a_d = '0;
                  w_d = '0;
                  if (c_q < cfg_c_q) begin
                     c_d     = c_q + C_W'(1);
                     state_d = StLoad;
                  end else begin
                     c_d     = '0;
                     state_d = StPpu;
                  end
               end
            end
            StPpu: begin
               if (ppu_done) begin
                  if (k_q < cfg_k_q) begin
                     k_d     = k_q + K_W'(1);
                     state_d = StLoad;
                  end else if (layer_q < cfg_layers_q) begin
                     k_d     = '0;
                     layer_d = layer_q + L_W'(1);
                     state_d = StLoad;
                  end else begin
                     state_d = StDone;
                     done_d  = 1'b1;
                  end
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= StIdle;
         cfg_layers_q <= '0;
         cfg_k_q      <= '0;
         cfg_c_q      <= '0;
         layer_q      <= '0;
         k_q          <= '0;
         c_q          <= '0;
         a_q          <= '0;
         w_q          <= '0;
         cnt_a_q      <= '0;
         cnt_w_q      <= '0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cfg_layers_q <= cfg_layers_d;
         cfg_k_q      <= cfg_k_d;
         cfg_c_q      <= cfg_c_d;
         layer_q      <= layer_d;
         k_q          <= k_d;
         c_q          <= c_d;
         a_q          <= a_d;
         w_q          <= w_d;
         cnt_a_q      <= cnt_a_d;
         cnt_w_q      <= cnt_w_d;
         done_q       <= done_d;
      end
   end

endmodule

// File: tb/tb_pe_dataflow_sequencer.sv
// Bench for pe_dataflow_sequencer: table of single-tile runs checked through a beat
// scoreboard, plus hand-written reset, backpressure, loop-nesting and abort sequences.
module tb_pe_dataflow_sequencer;

   localparam int I = 4;
   localparam int F = 4;

   logic       clk, rst, start, abort, load_done, mul_ready, ppu_done;
   logic [2:0] cfg_num_layers;
   logic [3:0] cfg_num_k, cfg_num_c;
   logic [6:0] load_cnt_a, load_cnt_w;
   logic [2:0] state;
   logic [2:0] current_layer;
   logic [3:0] current_k, current_c;
   logic [6:0] current_a, current_w, remain_a, remain_w;
   logic       flag_remain_a, flag_remain_w, mul_valid, busy, done;

   pe_dataflow_sequencer dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .cfg_num_layers(cfg_num_layers), .cfg_num_k(cfg_num_k), .cfg_num_c(cfg_num_c),
      .load_done(load_done), .load_cnt_a(load_cnt_a), .load_cnt_w(load_cnt_w),
      .mul_ready(mul_ready), .ppu_done(ppu_done), .state(state),
      .current_layer(current_layer), .current_k(current_k), .current_c(current_c),
      .current_a(current_a), .current_w(current_w), .remain_a(remain_a),
      .remain_w(remain_w), .flag_remain_a(flag_remain_a), .flag_remain_w(flag_remain_w),
      .mul_valid(mul_valid), .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int a; int w; int ra; int rw; int fa; int fw;
   } beat_t;

   typedef struct {
      int ca; int cw; int beats; int cyc;
   } vec_t;

   beat_t sbq[$];
   vec_t  vecs[8];
   int    total, bad, beats, comp_cyc, done_cnt;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Expected issue order: weight group outer, activation group inner.
   task automatic push_tile(input int ca, input int cw);
      beat_t e;
      for (int w = 0; w < cw; w += F) begin
         for (int a = 0; a < ca; a += I) begin
            e.a  = a;
            e.w  = w;
            e.ra = ca - a;
            e.rw = cw - w;
            e.fa = (ca - a) >= I ? 1 : 0;
            e.fw = (cw - w) >= F ? 1 : 0;
            sbq.push_back(e);
         end
      end
   endtask

   task automatic step();
      beat_t e;
      @(negedge clk);
      if (state == 3'd2) comp_cyc++;
      if (done) done_cnt++;
      if (mul_valid && mul_ready) begin
         beats++;
         if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL beat_unexpected: got beat a=%0d w=%0d required none",
                     current_a, current_w);
         end else begin
            e = sbq.pop_front();
            chk("beat_a", int'(current_a), e.a);
            chk("beat_w", int'(current_w), e.w);
            chk("beat_remain_a", int'(remain_a), e.ra);
            chk("beat_remain_w", int'(remain_w), e.rw);
            chk("beat_flag_a", int'(flag_remain_a), e.fa);
            chk("beat_flag_w", int'(flag_remain_w), e.fw);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic start_run(input int nl, input int nk, input int nc);
      cfg_num_layers = 3'(nl);
      cfg_num_k      = 4'(nk);
      cfg_num_c      = 4'(nc);
      start = 1'b1;
      step();
      start = 1'b0;
      chk("start_to_load", int'(state), 1);
   endtask

   task automatic load_tile(input int ca, input int cw);
      load_done  = 1'b1;
      load_cnt_a = 7'(ca);
      load_cnt_w = 7'(cw);
      step();
      load_done = 1'b0;
      chk("load_to_compute", int'(state), 2);
      push_tile(ca, cw);
   endtask

   task automatic run_tile(input int ca, input int cw, input int exp_beats, input int exp_cyc);
      start_run(0, 0, 0);
      mul_ready = 1'b1;
      load_tile(ca, cw);
      beats    = 0;
      comp_cyc = 0;
      for (int g = 0; g < 400 && state == 3'd2; g++) step();
      chk("tile_beats", beats, exp_beats);
      chk("tile_compute_cycles", comp_cyc, exp_cyc);
      chk("tile_to_ppu", int'(state), 3);
      chk("tile_sb_empty", sbq.size(), 0);
      ppu_done = 1'b1;
      step();
      ppu_done = 1'b0;
      chk("ppu_to_done", int'(state), 4);
      chk("done_pulse", int'(done), 1);
      step();
      chk("done_cleared", int'(done), 0);
      chk("done_holds", int'(state), 4);
   endtask

   initial begin
      int rdy[4];
      int exp_a[4];
      vecs[0] = '{ca: 8,  cw: 4,  beats: 2,   cyc: 2};
      vecs[1] = '{ca: 6,  cw: 5,  beats: 4,   cyc: 4};
      vecs[2] = '{ca: 4,  cw: 4,  beats: 1,   cyc: 1};
      vecs[3] = '{ca: 1,  cw: 1,  beats: 1,   cyc: 1};
      vecs[4] = '{ca: 64, cw: 64, beats: 256, cyc: 256};
      vecs[5] = '{ca: 0,  cw: 4,  beats: 0,   cyc: 1};
      vecs[6] = '{ca: 5,  cw: 0,  beats: 0,   cyc: 1};
      vecs[7] = '{ca: 3,  cw: 9,  beats: 3,   cyc: 3};
      rdy   = '{1, 0, 0, 1};
      exp_a = '{0, 4, 4, 4};

      total = 0; bad = 0; beats = 0; comp_cyc = 0; done_cnt = 0;
      rst = 1'b0; start = 1'b0; abort = 1'b0; load_done = 1'b0; mul_ready = 1'b0;
      ppu_done = 1'b0; cfg_num_layers = '0; cfg_num_k = '0; cfg_num_c = '0;
      load_cnt_a = '0; load_cnt_w = '0;

      #3;
      chk("rst_state", int'(state), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_mul_valid", int'(mul_valid), 0);
      chk("rst_remain_a", int'(remain_a), 0);
      chk("rst_flag_a", int'(flag_remain_a), 0);
      @(posedge clk);
      #1;
      rst = 1'b1;

      for (int v = 0; v < 8; v++) run_tile(vecs[v].ca, vecs[v].cw, vecs[v].beats, vecs[v].cyc);

      // Backpressure: stalled cycles must hold current_a; a start mid-run is ignored.
      start_run(0, 0, 0);
      load_tile(8, 4);
      beats    = 0;
      comp_cyc = 0;
      for (int i = 0; i < 4; i++) begin
         mul_ready = rdy[i][0];
         start     = (i == 1);
         chk("bp_current_a", int'(current_a), exp_a[i]);
         chk("bp_mul_valid", int'(mul_valid), 1);
         step();
      end
      start = 1'b0;
      chk("bp_to_ppu", int'(state), 3);
      chk("bp_beats", beats, 2);
      chk("bp_cycles", comp_cyc, 4);
      ppu_done = 1'b1;
      step();
      ppu_done = 1'b0;
      chk("bp_done_state", int'(state), 4);

      // Loop nesting: 2 layers x 2 k x 2 c, one beat per tile.
      start_run(1, 1, 1);
      mul_ready = 1'b1;
      done_cnt  = 0;
      for (int it = 0; it < 4; it++) begin
         for (int c = 0; c < 2; c++) begin
            chk("nest_in_load", int'(state), 1);
            chk("nest_c", int'(current_c), c);
            chk("nest_k", int'(current_k), it % 2);
            chk("nest_layer", int'(current_layer), it / 2);
            load_tile(4, 4);
            step();
            chk("nest_after_compute", int'(state), (c == 0) ? 1 : 3);
         end
         ppu_done = 1'b1;
         step();
         ppu_done = 1'b0;
         chk("nest_after_ppu", int'(state), (it == 3) ? 4 : 1);
      end
      step();
      step();
      chk("nest_done_pulses", done_cnt, 1);
      chk("nest_sb_empty", sbq.size(), 0);

      // Abort in PPU beats a simultaneous ppu_done; no done pulse follows.
      start_run(0, 0, 0);
      load_tile(4, 4);
      step();
      chk("abort_in_ppu", int'(state), 3);
      done_cnt = 0;
      abort    = 1'b1;
      ppu_done = 1'b1;
      step();
      abort    = 1'b0;
      ppu_done = 1'b0;
      chk("abort_idle", int'(state), 0);
      chk("abort_busy", int'(busy), 0);
      chk("abort_remain_w", int'(remain_w), 0);
      step();
      chk("abort_no_done", done_cnt, 0);
      run_tile(8, 4, 2, 2);

      // Asynchronous reset mid-COMPUTE, observed before the next clock edge.
      start_run(0, 0, 0);
      mul_ready = 1'b1;
      load_tile(8, 4);
      step();
      chk("pre_rst_a", int'(current_a), 4);
      #2;
      rst = 1'b0;
      #1;
      chk("arst_state", int'(state), 0);
      chk("arst_mul_valid", int'(mul_valid), 0);
      chk("arst_current_a", int'(current_a), 0);
      chk("arst_remain_a", int'(remain_a), 0);
      chk("arst_remain_w", int'(remain_w), 0);
      chk("arst_busy", int'(busy), 0);
      sbq.delete();
      @(posedge clk);
      #1;
      rst = 1'b1;
      run_tile(6, 5, 4, 4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
